// File: rtl/aes_pkg.sv
// Shared AES-128 constants and the iterative decryptor state encoding.
package aes_pkg;

  localparam int unsigned ROUNDS  = 10;
  localparam int unsigned BYTES   = 16;
  localparam int unsigned LATENCY = 382;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned MSG_W   = BYTE_W * BYTES;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    INV_SHIFT,
    INV_SUB,
    ADD_RK,
    INV_MIX,
    DONE
  } state_e;

endpackage

// File: rtl/inv_sub_bytes.sv
// AES inverse S-box as a purely combinational 256x8 lookup.
module inv_sub_bytes (
  input  logic [7:0] data,
  output logic [7:0] sub_c
);

  // Entry for address a sits at bits [8*(255-a) +: 8], i.e. row-major as printed in FIPS-197.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign sub_c = INV_SBOX[{~data, 3'b000} +: 8];

endmodule

// File: rtl/decrypt.sv
// Iterative byte-serial AES-128 decryptor; round keys are fetched one byte per cycle
// from an external key source addressed by key_round/key_idx.
module decrypt #(
  parameter int unsigned ROUNDS = aes_pkg::ROUNDS
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         start,
  input  logic [7:0]   in,
  input  logic [7:0]   key,
  output logic [3:0]   key_round,
  output logic [3:0]   key_idx,
  output logic         busy,
  output logic         done,
  output logic [127:0] message
);
  import aes_pkg::*;

  state_e             state, state_d;
  logic [CNT_W-1:0]   round, round_d;
  logic [CNT_W-1:0]   idx, idx_d;
  logic [MSG_W-1:0]   message_d;
  logic [CNT_W-1:0]   key_round_d, key_idx_d;
  logic               busy_d, done_d, key_on;
  logic               last_byte, last_col;
  logic [7:0]         cur_byte, sbox_c;
  logic [31:0]        cur_col;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply by a 4-bit constant (enough for 09/0b/0d/0e).
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] b2, b4, b8;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    return ({8{c[0]}} & b) ^ ({8{c[1]}} & b2) ^ ({8{c[2]}} & b4) ^ ({8{c[3]}} & b8);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
            gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
            gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
            gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
  endfunction

  // Row r rotates right by r: new[r+4c] = old[r+4((c-r) mod 4)].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] res;
    res = s;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        res[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
      end
    end
    return res;
  endfunction

  assign cur_byte  = message[{~idx, 3'b000} +: 8];
  assign cur_col   = message[{~idx[1:0], 5'b00000} +: 32];
  assign last_byte = (idx == CNT_W'(BYTES - 1));
  assign last_col  = (idx == CNT_W'(3));

  inv_sub_bytes u_inv_sub_bytes (
    .data  (cur_byte),
    .sub_c (sbox_c)
  );

  // State register and all registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      round     <= '0;
      idx       <= '0;
      message   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      key_round <= '0;
      key_idx   <= '0;
    end else begin
      state     <= state_d;
      round     <= round_d;
      idx       <= idx_d;
      message   <= message_d;
      busy      <= busy_d;
      done      <= done_d;
      key_round <= key_round_d;
      key_idx   <= key_idx_d;
    end
  end

  // Next-state, counters and next values of the registered outputs.
  always_comb begin
    state_d = state;
    round_d = round;
    idx_d   = idx;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          round_d = CNT_W'(ROUNDS);
          idx_d   = '0;
        end
      end
      LOAD: begin
        idx_d = idx + CNT_W'(1);
        if (last_byte) begin
          state_d = INV_SHIFT;
          idx_d   = '0;
          round_d = round - CNT_W'(1);
        end
      end
      INV_SHIFT: begin
        state_d = INV_SUB;
      end
      INV_SUB: begin
        idx_d = idx + CNT_W'(1);
        if (last_byte) begin
          state_d = ADD_RK;
          idx_d   = '0;
        end
      end
      ADD_RK: begin
        idx_d = idx + CNT_W'(1);
        if (last_byte) begin
          idx_d   = '0;
          state_d = (round != '0) ? INV_MIX : DONE;
        end
      end
      INV_MIX: begin
        idx_d = idx + CNT_W'(1);
        if (last_col) begin
          state_d = INV_SHIFT;
          idx_d   = '0;
          round_d = round - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d      = (state_d != IDLE) && (state_d != DONE);
    done_d      = (state_d == DONE);
    key_on      = (state_d == LOAD) || (state_d == ADD_RK);
    key_round_d = key_on ? round_d : '0;
    key_idx_d   = key_on ? idx_d : '0;
  end

  // Datapath: one byte (or one column) of the state is rewritten per cycle.
  always_comb begin
    message_d = message;
    unique case (state)
      LOAD:      message_d[{~idx, 3'b000} +: 8] = in ^ key;
      INV_SHIFT: message_d = inv_shift_rows(message);
      INV_SUB:   message_d[{~idx, 3'b000} +: 8] = sbox_c;
      ADD_RK:    message_d[{~idx, 3'b000} +: 8] = cur_byte ^ key;
      INV_MIX:   message_d[{~idx[1:0], 5'b00000} +: 32] = inv_mix_col(cur_col);
      default:   message_d = message;
    endcase
  end

endmodule

// File: tb/tb_decrypt.sv
// Scoreboard bench for decrypt: FIPS-197 vectors, key-request tracking, start abuse and reset abort.
module tb_decrypt;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam int LAT = 382;

  logic         clock = 1'b0;
  logic         resetn;
  logic         start;
  logic [7:0]   in;
  logic [7:0]   key;
  logic [3:0]   key_round;
  logic [3:0]   key_idx;
  logic         busy;
  logic         done;
  logic [127:0] message;

  typedef struct {
    logic [127:0] msg;
    int           c0;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       cur_e;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         key_err = 0;
  int         idle_key_err = 0;
  int         last_c0 = 0;
  int         t_off;
  logic [7:0] rk [0:10][0:15];
  logic [3:0] exp_kr [LAT];
  logic [3:0] exp_ki [LAT];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  decrypt #(.ROUNDS(10)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .in        (in),
    .key       (key),
    .key_round (key_round),
    .key_idx   (key_idx),
    .busy      (busy),
    .done      (done),
    .message   (message)
  );

  // External key source: combinational lookup of the requested round-key byte.
  assign key = (key_round <= 4'd10) ? rk[key_round][key_idx] : 8'h00;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Forward S-box from first principles: x^254 then the affine map.
  function automatic logic [7:0] sbox_tb(input logic [7:0] x);
    logic [7:0] p;
    p = 8'h01;
    for (int i = 0; i < 254; i++) p = gm(p, x);
    return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
  endfunction

  task automatic expand_key(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tb(t[31:24]), sbox_tb(t[23:16]), sbox_tb(t[15:8]), sbox_tb(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      for (int j = 0; j < 16; j++)
        rk[r][j] = w[4*r + j/4][31 - 8*(j%4) -: 8];
  endtask

  // Expected (key_round,key_idx) per cycle offset from the accepting edge.
  initial begin
    int t;
    for (int i = 0; i < LAT; i++) begin exp_kr[i] = 4'd0; exp_ki[i] = 4'd0; end
    for (int i = 0; i < 16; i++) begin exp_kr[i] = 4'd10; exp_ki[i] = 4'(i); end
    t = 16;
    for (int r = 9; r >= 0; r--) begin
      t = t + 17;
      for (int i = 0; i < 16; i++) begin exp_kr[t] = 4'(r); exp_ki[t] = 4'(i); t++; end
      if (r > 0) t = t + 4;
    end
  end

  // Monitor: key-request tracking every cycle, result/latency checks on done.
  always @(negedge clock) begin
    if (resetn) begin
      if (sb_q.size() > 0 && cyc >= sb_q[0].c0 && cyc < sb_q[0].c0 + LAT) begin
        t_off = cyc - sb_q[0].c0;
        if (key_round !== exp_kr[t_off] || key_idx !== exp_ki[t_off]) key_err++;
      end else if (key_round !== 4'd0 || key_idx !== 4'd0) begin
        idle_key_err++;
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          check("spurious_done", 128'(done), 128'(0));
        end else begin
          cur_e = sb_q.pop_front();
          check("message", message, cur_e.msg);
          check("latency", 128'(cyc), 128'(cur_e.c0 + LAT));
          check("key_seq_errors", 128'(key_err), 128'(0));
          key_err = 0;
        end
      end
    end
  end

  // Called right after a negedge: start on this cycle, stream 16 bytes on the following ones.
  task automatic run_op(input logic [127:0] k, input logic [127:0] ct, input logic [127:0] pt,
                        input bit hold_start);
    expand_key(k);
    start   = 1'b1;
    in      = 8'h00;
    last_c0 = cyc + 1;
    sb_q.push_back('{pt, cyc + 1});
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      start = hold_start;
      in    = ct[127 - 8*i -: 8];
    end
    @(negedge clock);
    in = 8'h00;
  endtask

  task automatic wait_done(input bit hold_start);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clock);
      if (hold_start) start = busy;
      seen = done;
    end
    start = 1'b0;
    if (!seen) check("done_timeout", 128'(0), 128'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    start  = 1'b1;
    in     = 8'h00;
    expand_key(K1);
    repeat (3) @(negedge clock);
    check("rst_message", message, 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_key_round", 128'(key_round), 128'(0));
    check("rst_key_idx", 128'(key_idx), 128'(0));
    start = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_busy", 128'(busy), 128'(0));

    // FIPS-197 C.1 vector
    run_op(K1, C1, P1, 1'b0);
    check("busy_mid", 128'(busy), 128'(1));
    wait_done(1'b0);
    @(negedge clock);
    check("done_one_cycle", 128'(done), 128'(0));
    check("busy_after_done", 128'(busy), 128'(0));
    repeat (5) @(negedge clock);
    check("hold_p1", message, P1);

    // FIPS-197 appendix B vector
    run_op(K2, C2, P2, 1'b0);
    wait_done(1'b0);
    repeat (3) @(negedge clock);
    check("hold_p2", message, P2);

    // start held high throughout an operation
    run_op(K1, C1, P1, 1'b1);
    wait_done(1'b1);
    repeat (20) @(negedge clock);
    check("no_restart_busy", 128'(busy), 128'(0));
    check("no_restart_msg", message, P1);

    // reset abort at cycle 200
    run_op(K2, C2, P2, 1'b0);
    while (cyc < last_c0 + 200) @(negedge clock);
    resetn = 1'b0;
    #1;
    check("abort_message", message, 128'(0));
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_key_round", 128'(key_round), 128'(0));
    sb_q.delete();
    key_err = 0;
    @(negedge clock);
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    check("post_abort_message", message, 128'(0));
    check("post_abort_busy", 128'(busy), 128'(0));
    run_op(K1, C1, P1, 1'b0);
    wait_done(1'b0);

    // back-to-back: start on the cycle after done
    @(negedge clock);
    run_op(K2, C2, P2, 1'b0);
    wait_done(1'b0);
    @(negedge clock);
    check("b2b_hold_p2", message, P2);
    run_op(K1, C1, P1, 1'b0);
    wait_done(1'b0);
    repeat (5) @(negedge clock);
    check("final_hold", message, P1);

    check("scoreboard_empty", 128'(sb_q.size()), 128'(0));
    check("idle_key_requests", 128'(idle_key_err), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decrypt.md
DECRYPT -- requirements
Module: decrypt

Interface
REQ-001 SHALL have parameter ROUNDS, default 10, meaning the AES-128 round count; only 10 is supported.
REQ-002 SHALL have port clock, input, 1, meaning the single clock; all flops are rising-edge.
REQ-003 SHALL have port resetn, input, 1, meaning the asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, meaning a one-cycle request, sampled only in IDLE.
REQ-005 SHALL have port in, input, 8, meaning a ciphertext byte, valid in the 16 cycles after start, byte 0 first.
REQ-006 SHALL have port key, input, 8, meaning a round-key byte driven combinationally by an external key source from key_round/key_idx in the same cycle.
REQ-007 SHALL have port key_round, output, 4, meaning the round key currently requested (10..0).
REQ-008 SHALL have port key_idx, output, 4, meaning the byte index currently requested (0..15).
REQ-009 SHALL have port busy, output, 1, meaning high in every state except IDLE and DONE.
REQ-010 SHALL have port done, output, 1, meaning a one-cycle completion pulse.
REQ-011 SHALL have port message, output, 128, meaning the state/plaintext register, byte i = message[127-8i -: 8], column-major (row i%4, col i/4).

Function
REQ-012 SHALL implement the states IDLE, LOAD, INV_SHIFT, INV_SUB, ADD_RK, INV_MIX and DONE in a registered FSM with a 4-bit round counter and a 4-bit byte counter.
REQ-013 SHALL leave IDLE on edge E0 (start=1) for LOAD, clearing round to 10 and idx to 0.
REQ-014 SHALL, in LOAD (edges E1..E16), write message byte idx = in ^ key with key_round=10, then go to INV_SHIFT with round=9.
REQ-015 SHALL, in INV_SHIFT (1 cycle), apply new[r+4c] = old[r+4((c-r) mod 4)] to all 16 bytes at once, then go to INV_SUB.
REQ-016 SHALL, in INV_SUB (16 cycles, idx 0..15), replace byte idx with InvSbox(byte idx), then go to ADD_RK.
REQ-017 SHALL, in ADD_RK (16 cycles), XOR byte idx with key for key_round=round; it then goes to INV_MIX if round>0, otherwise to DONE.
REQ-018 SHALL, in INV_MIX (4 cycles, column c=idx 0..3), replace column c with InvMixColumns (coefficients 0e,0b,0d,09 over GF(2^8), poly 0x11b), then decrement round and go to INV_SHIFT.
REQ-019 SHALL hold key_round/key_idx at 0 outside LOAD/ADD_RK; the key value is ignored there.
REQ-020 SHALL make the latency exactly 382 cycles, with done high for the cycle after edge E0+382.
REQ-021 SHALL have DONE last one cycle and return to IDLE, and SHALL hold message unchanged from DONE until the next start is accepted.
REQ-022 SHALL ignore start whenever the block is not in IDLE; start together with reset is also ignored.
REQ-023 SHALL wrap the byte counter 15->0 only on state exit and never overflow into round.

Reset
REQ-024 SHALL, while resetn=0, immediately force state to IDLE, message to 0, round to 0, idx to 0, busy to 0, done to 0, key_round to 0 and key_idx to 0.
REQ-025 SHALL abort a mid-operation reset with no output change after release; the first start after release begins a fresh decryption.

Structure
REQ-026 SHALL take the state encoding, ROUNDS, BYTES=16 and LATENCY=382 from shared package aes_pkg.
REQ-027 SHALL implement the inverse S-box as sub-module inv_sub_bytes (combinational 256x8 ROM).
REQ-028 SHALL keep the InvMixColumns and InvShiftRows logic inside decrypt as functions.

Verification
REQ-029 SHALL cover this scenario: key 000102030405060708090a0b0c0d0e0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> message 00112233445566778899aabbccddeeff with done at E0+382.
REQ-030 SHALL cover this scenario: key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32 -> message 3243f6a8885a308d313198a2e0370734.
REQ-031 SHALL cover this scenario: start pulsed every cycle during an operation -> single done, correct result, no restart.
REQ-032 SHALL cover this scenario: resetn=0 at cycle 200 of an operation -> message=0, busy=0 immediately; a following start on the vector from REQ-029 gives the correct result.
REQ-033 SHALL cover this scenario: bench key model checks each (key_round,key_idx) request sequence -> 10/0..15, then 9..0 each 0..15, with no other nonzero requests.
REQ-034 SHALL cover this scenario: two back-to-back operations with start on the cycle after done -> both correct, and message holds between them.
